// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the requesters and the register-file arbiter,
// plus the four registered write ports driven towards the register file.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 6
);
  logic [NUM_REQ-1:0]            i_Req_Valid;
  logic [2*NUM_REQ-1:0]          i_Req_Thread;
  logic [5*NUM_REQ-1:0]          i_Req_Reg;
  logic [DATA_WIDTH*NUM_REQ-1:0] i_Req_Data;
  logic [NUM_REQ-1:0]            o_Req_Ready;
  logic                          i_Stall;
  logic [3:0]                    o_Write_Enable;
  logic [27:0]                   o_Write_Addr;
  logic [4*DATA_WIDTH-1:0]       o_Write_Data;
  logic [2:0]                    o_Grant_Count;

  modport master (
    output i_Req_Valid, i_Req_Thread, i_Req_Reg, i_Req_Data, i_Stall,
    input  o_Req_Ready, o_Write_Enable, o_Write_Addr, o_Write_Data, o_Grant_Count
  );

  modport slave (
    input  i_Req_Valid, i_Req_Thread, i_Req_Reg, i_Req_Data, i_Stall,
    output o_Req_Ready, o_Write_Enable, o_Write_Addr, o_Write_Data, o_Grant_Count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: up to 4 grants per cycle onto 4 register-file write ports.
// Optional WB_SAME_ADDR_SERIALIZE_EN defers a request whose address was already granted this cycle.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 6
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [3:0]                      we_q, we_d;
  logic [3:0][6:0]                 addr_q, addr_d;
  logic [3:0][DATA_WIDTH-1:0]      data_q, data_d;
  logic [2:0]                      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]              ready;

  // NOTE: blocking assignments here are intentional -- cnt_d is a running
  // counter read back within the same scan, and every output gets a default first.
  always_comb begin
    int              idx;
    logic [6:0]      pa;
    logic            conflict;
    logic            any_grant;
    logic [PTR_W-1:0] last;

    ready     = '0;
    we_d      = '0;
    addr_d    = '0;
    data_d    = '0;
    cnt_d     = '0;
    last      = rr_ptr_q;
    any_grant = 1'b0;
    idx       = 0;
    pa        = '0;
    conflict  = 1'b0;

    if (!i_Rst && !bus.i_Stall) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        pa = {bus.i_Req_Thread[2*idx +: 2], bus.i_Req_Reg[5*idx +: 5]};
        conflict = 1'b0;
`ifdef WB_SAME_ADDR_SERIALIZE_EN
        for (int p = 0; p < 4; p++) begin
          if (p < int'(cnt_d) && addr_d[p] == pa) conflict = 1'b1;
        end
`endif
        if (bus.i_Req_Valid[idx]) begin
          // Writes to r0 are architecturally dropped: accept them without a port.
          if (pa[4:0] == 5'd0) begin
            ready[idx] = 1'b1;
          end else if (cnt_d < 3'd4 && !conflict) begin
            ready[idx]            = 1'b1;
            we_d[cnt_d[1:0]]      = 1'b1;
            addr_d[cnt_d[1:0]]    = pa;
            data_d[cnt_d[1:0]]    = bus.i_Req_Data[DATA_WIDTH*idx +: DATA_WIDTH];
            cnt_d                 = cnt_d + 3'd1;
            last                  = PTR_W'(idx);
            any_grant             = 1'b1;
          end
        end
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (any_grant) rr_ptr_d = (int'(last) == NUM_REQ - 1) ? '0 : last + PTR_W'(1);
  end

  // NOTE: asynchronous reset clears the write ports immediately, so a write
  // registered just before reset never reaches the register file.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rr_ptr_q <= '0;
      we_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_Req_Ready    = ready;
  assign bus.o_Write_Enable = we_q;
  assign bus.o_Write_Addr   = addr_q;
  assign bus.o_Write_Data   = data_q;
  assign bus.o_Grant_Count  = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (NUM_REQ=6, DATA_WIDTH=32).
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int NR = 6;

  typedef struct packed {
    logic [5:0]      valid;
    logic [5:0][1:0] th;
    logic [5:0][4:0] rg;
    logic            stall;
    logic [5:0]      ready;   // expected same-cycle ready
    logic [3:0][2:0] src;     // expected requester per port next cycle, 7 = unused
  } vec_t;

  localparam logic [5:0]      ALL  = 6'b111111;
  localparam logic [11:0]     TH0  = 12'h000;
  localparam logic [29:0]     RG_D = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [11:0]     NONE = {3'd7, 3'd7, 3'd7, 3'd7};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .i_Clk(clk), .i_Rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(int k);
    return 32'(32'h1111_1111 * (k + 1));
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_inputs(vec_t v);
    bus.i_Req_Valid  = v.valid;
    bus.i_Req_Thread = v.th;
    bus.i_Req_Reg    = v.rg;
    bus.i_Stall      = v.stall;
  endtask

  task automatic check_ports(string tag, vec_t v);
    logic [3:0]   exp_we;
    logic [27:0]  exp_addr;
    logic [127:0] exp_data;
    logic [2:0]   exp_cnt;
    exp_we = '0; exp_addr = '0; exp_data = '0; exp_cnt = '0;
    for (int p = 0; p < 4; p++) begin
      if (v.src[p] != 3'd7) begin
        exp_we[p]            = 1'b1;
        exp_addr[7*p +: 7]   = {v.th[v.src[p]], v.rg[v.src[p]]};
        exp_data[32*p +: 32] = data_of(int'(v.src[p]));
        exp_cnt              = exp_cnt + 3'd1;
      end
    end
    check({tag, ".we"},   128'(bus.o_Write_Enable), 128'(exp_we));
    check({tag, ".addr"}, 128'(bus.o_Write_Addr),   128'(exp_addr));
    check({tag, ".data"}, bus.o_Write_Data,         exp_data);
    check({tag, ".cnt"},  128'(bus.o_Grant_Count),  128'(exp_cnt));
  endtask

  task automatic run_vec(string tag, vec_t v);
    set_inputs(v);
    #1;
    check({tag, ".ready"}, 128'(bus.o_Req_Ready), 128'(v.ready));
    @(posedge clk);
    #1;
    check_ports(tag, v);
  endtask

  vec_t vecs[14];
  vec_t v_all;

  initial begin
    v_all = '{valid: ALL, th: TH0, rg: RG_D, stall: 1'b0, ready: 6'b001111,
              src: {3'd3, 3'd2, 3'd1, 3'd0}};

    vecs[0]  = v_all;
    vecs[1]  = '{ALL, TH0, RG_D, 1'b0, 6'b110011, {3'd1, 3'd0, 3'd5, 3'd4}};
    vecs[2]  = '{ALL, TH0, RG_D, 1'b1, 6'b000000, NONE};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = '{ALL, TH0, RG_D, 1'b0, 6'b111100, {3'd5, 3'd4, 3'd3, 3'd2}};
    vecs[6]  = '{6'b000100, {2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0},
                 {5'd6, 5'd5, 5'd4, 5'd0, 5'd2, 5'd1}, 1'b0, 6'b000100, NONE};
    vecs[7]  = v_all;
    vecs[8]  = '{ALL, TH0, {5'd6, 5'd0, 5'd4, 5'd3, 5'd2, 5'd0}, 1'b0, 6'b111111,
                 {3'd3, 3'd2, 3'd1, 3'd5}};
    vecs[9]  = '{6'b100001, TH0, RG_D, 1'b0, 6'b100001, {3'd7, 3'd7, 3'd0, 3'd5}};
    vecs[10] = '{6'b000000, TH0, RG_D, 1'b0, 6'b000000, NONE};
`ifdef WB_SAME_ADDR_SERIALIZE_EN
    vecs[11] = '{6'b001010, {2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0},
                 {5'd6, 5'd5, 5'd7, 5'd3, 5'd7, 5'd1}, 1'b0, 6'b000010, {3'd7, 3'd7, 3'd7, 3'd1}};
`else
    vecs[11] = '{6'b001010, {2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0},
                 {5'd6, 5'd5, 5'd7, 5'd3, 5'd7, 5'd1}, 1'b0, 6'b001010, {3'd7, 3'd7, 3'd3, 3'd1}};
`endif
    vecs[12] = '{6'b001000, {2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0},
                 {5'd6, 5'd5, 5'd7, 5'd3, 5'd7, 5'd1}, 1'b0, 6'b001000, {3'd7, 3'd7, 3'd7, 3'd3}};
    vecs[13] = '{6'b000001, TH0, {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd0}, 1'b1, 6'b000000, NONE};

    for (int k = 0; k < NR; k++) bus.i_Req_Data[DW*k +: DW] = data_of(k);
    set_inputs(v_all);

    // Reset state with every requester valid.
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 128'(bus.o_Req_Ready), 128'(0));
    check_ports("rst", '{ALL, TH0, RG_D, 1'b0, 6'b0, NONE});
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset pulsed right after a 4-grant handshake (pointer is 4 here).
    set_inputs(v_all);
    #1;
    check("rp.ready", 128'(bus.o_Req_Ready), 128'(6'b110011));
    @(posedge clk);
    #1;
    check_ports("rp.pre", '{ALL, TH0, RG_D, 1'b0, 6'b0, {3'd1, 3'd0, 3'd5, 3'd4}});
    rst = 1'b1;
    #1;
    check("rp.rst_ready", 128'(bus.o_Req_Ready), 128'(0));
    check_ports("rp.rst", '{ALL, TH0, RG_D, 1'b0, 6'b0, NONE});
    @(posedge clk);
    #1;
    check_ports("rp.hold", '{ALL, TH0, RG_D, 1'b0, 6'b0, NONE});
    rst = 1'b0;
    run_vec("rp.post", v_all);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of one register word.
REQ-002 SHALL have parameter NUM_REQ, default 6, meaning the number of writeback requesters (legal range 4..8).
REQ-003 SHALL have fixed physical address width 7 = {thread[1:0], reg[4:0]}.
REQ-004 SHALL use one clock, i_Clk, and an asynchronous, active-high reset, i_Rst.
REQ-005 Ports, in the order name / direction / width / meaning:
- i_Clk / in / 1 / clock.
- i_Rst / in / 1 / async active-high reset.
- i_Req_Valid / in / NUM_REQ / request valid, one bit per requester.
- i_Req_Thread / in / 2*NUM_REQ / thread id, packed, requester k at [2k+1:2k].
- i_Req_Reg / in / 5*NUM_REQ / architectural register, packed.
- i_Req_Data / in / DATA_WIDTH*NUM_REQ / write data, packed.
- o_Req_Ready / out / NUM_REQ / request accepted this cycle.
- i_Stall / in / 1 / suppress all grants.
- o_Write_Enable / out / 4 / register file write enables.
- o_Write_Addr / out / 28 / 4 x 7-bit physical addresses.
- o_Write_Data / out / 4*DATA_WIDTH / 4 x write data.
- o_Grant_Count / out / 3 / number of ports enabled this cycle (0..4).

Function
REQ-006 Requester k SHALL complete a handshake in a cycle where i_Req_Valid[k] and o_Req_Ready[k] are both 1; o_Req_Ready SHALL be combinational from the current inputs and state.
REQ-007 Valid requests with reg==0 SHALL get o_Req_Ready=1 in the same cycle and SHALL consume no port and cause no write.
REQ-008 At most 4 other valid requests SHALL be granted per cycle, selected in round-robin order starting at pointer rr_ptr (range 0..NUM_REQ-1) and scanning upward with wrap.
REQ-009 Granted requests SHALL be assigned to write ports 0,1,2,3 in scan order.
REQ-010 Each granted request SHALL appear on its port exactly one cycle after the handshake (registered): enable 1, addr {thread,reg}, data.
REQ-011 Unused ports SHALL drive enable 0, addr 0, data 0.
REQ-012 After any cycle with at least one port grant, rr_ptr SHALL become (index of last granted requester + 1) mod NUM_REQ; otherwise it SHALL hold.
REQ-013 While i_Stall=1: o_Req_Ready SHALL be all 0, including reg==0 requests; next-cycle enables SHALL be 0; rr_ptr SHALL hold.
REQ-014 o_Grant_Count SHALL equal the popcount of o_Write_Enable, registered with it.
REQ-015 A requester that is not granted SHALL see o_Req_Ready=0 and SHALL hold its request; the arbiter SHALL store no pending request.
REQ-016 With NUM_REQ<=4, every valid request SHALL be granted in the same cycle, subject to REQ-013 and REQ-019.

Reset
REQ-017 While i_Rst=1: o_Write_Enable=0, o_Write_Addr=0, o_Write_Data=0, o_Grant_Count=0, rr_ptr=0, and o_Req_Ready=0 (forced combinationally).
REQ-018 Reset assertion mid-operation SHALL discard the registered writes immediately; the first grant SHALL be allowed in the first clock edge after deassertion.

Configuration
REQ-019 With macro WB_SAME_ADDR_SERIALIZE_EN defined: a request SHALL NOT be granted if its physical address equals that of a request already granted earlier in the same scan; it SHALL be deferred (ready 0).
REQ-020 Without WB_SAME_ADDR_SERIALIZE_EN: same-address requests SHALL be granted together; the higher-numbered port's data prevails in the register file.

Verification
REQ-021 Reset release, then NUM_REQ=6 requesters all valid with distinct addresses, i_Stall=0 -> cycle 1: ready=6'b001111; cycle 2: ports 0-3 write requesters 0-3; rr_ptr=4. Next cycle ready=6'b110011.
REQ-022 Requester 2 only, thread 1, reg 0 -> ready[2]=1 immediately; o_Write_Enable stays 0 next cycle; rr_ptr unchanged.
REQ-023 Requesters 1 and 3 both target thread 2, reg 7, with the macro defined -> only requester 1 granted, addr 7'h47; requester 3 granted the following cycle. Without the macro -> both granted on ports 0 and 1.
REQ-024 i_Stall=1 with all requests valid for 3 cycles -> ready all 0, enables 0, rr_ptr held; stall released -> grants resume from the held rr_ptr.
REQ-025 i_Rst pulsed the cycle after a 4-grant handshake -> o_Write_Enable=0 and o_Grant_Count=0 at once, no write reaches the register file, rr_ptr=0 after release.
